interrupt_controller: RTL and testbench

- Collects interrupt raise lines from bus peripherals (timer, mouse, IR, spares) and latches each as a pending bit.
- Masks pending bits and arbitrates them by fixed priority. Presents exactly one request at a time to the processor, with no nesting.
- Returns a per-source acknowledge pulse to the peripheral.
- Mask and pending state are memory-mapped on the 8-bit processor data bus.

---
 rtl/interrupt_controller.sv | 76 +++++++
 tb/tb_interrupt_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, maskable, fixed-priority interrupt controller with a bus register interface
module interrupt_controller #(
    parameter int         NUM_IRQ    = 4,
    parameter logic [7:0] BASE_ADDR  = 8'hE0,
    parameter logic [7:0] MASK_RESET = 8'h00
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] IRQ_RAISE,
    output logic [NUM_IRQ-1:0] IRQ_ACK,
    output logic               CPU_INT,
    output logic [2:0]         CPU_INT_ID,
    input  logic               CPU_INT_ACK,
    input  logic               CPU_INT_DONE,
    input  logic [7:0]         BUS_ADDR,
    input  logic [7:0]         BUS_DATA_IN,
    input  logic               BUS_WE,
    output logic [7:0]         BUS_DATA_OUT,
    output logic               BUS_DATA_OE
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, SERVICE = 2'd2} state_t;
    localparam logic [7:0] VALID = 8'((9'd1 << NUM_IRQ) - 9'd1);
    state_t state, state_n;
    logic [NUM_IRQ-1:0] raise_q;
    logic [7:0] mask, pending, pending_n, req, edge_set, id_onehot, offset;
    logic [2:0] id, id_n, sel;
    logic wr_mask, wr_pend, ack_take;
    always_comb begin
        offset    = BUS_ADDR - BASE_ADDR;
        wr_mask   = BUS_WE && offset == 8'd0;
        wr_pend   = BUS_WE && offset == 8'd1;
        req       = pending & mask;
        id_onehot = 8'd1 << id;
        ack_take  = state == REQUEST && CPU_INT_ACK;
        edge_set  = 8'(IRQ_RAISE & ~raise_q);
        sel       = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (req[i]) sel = 3'(i);
        // an edge arriving in the same cycle as any clear must win
        pending_n = (pending & ~(wr_pend ? BUS_DATA_IN : 8'd0) & ~(ack_take ? id_onehot : 8'd0)) | edge_set;
        state_n   = state;
        id_n      = id;
        case (state)
            IDLE: begin
                state_n = |req ? REQUEST : IDLE;
                id_n    = |req ? sel : id;
            end
            REQUEST: state_n = CPU_INT_ACK ? SERVICE : (|(mask & id_onehot) ? REQUEST : IDLE);
            SERVICE: state_n = CPU_INT_DONE ? IDLE : SERVICE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            id      <= 3'd0;
            mask    <= MASK_RESET & VALID;
            pending <= 8'd0;
            raise_q <= '0;
            IRQ_ACK <= '0;
        end else begin
            state   <= state_n;
            id      <= id_n;
            mask    <= wr_mask ? BUS_DATA_IN & VALID : mask;
            pending <= pending_n & VALID;
            raise_q <= IRQ_RAISE;
            IRQ_ACK <= ack_take ? id_onehot[NUM_IRQ-1:0] : '0;
        end
    end
    assign CPU_INT      = state == REQUEST;
    assign CPU_INT_ID   = id;
    assign BUS_DATA_OE  = !BUS_WE && offset < 8'd3;
    assign BUS_DATA_OUT = !BUS_DATA_OE ? 8'd0 :
                          offset == 8'd0 ? mask :
                          offset == 8'd1 ? pending : {state, 3'b000, id};
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: table-driven vectors plus directed corner-case sequences
module tb_interrupt_controller;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [3:0] raise = '0, irq_ack;
    logic cpu_int, ack = 1'b0, done = 1'b0, we = 1'b0, oe;
    logic [2:0] id;
    logic [7:0] addr = '0, din = '0, dout;
    int checks = 0, errors = 0, reqs;

    interrupt_controller #(.NUM_IRQ(4), .BASE_ADDR(8'hE0), .MASK_RESET(8'hF5)) dut (
        .CLK(clk), .RESET(rst), .IRQ_RAISE(raise), .IRQ_ACK(irq_ack),
        .CPU_INT(cpu_int), .CPU_INT_ID(id), .CPU_INT_ACK(ack), .CPU_INT_DONE(done),
        .BUS_ADDR(addr), .BUS_DATA_IN(din), .BUS_WE(we),
        .BUS_DATA_OUT(dout), .BUS_DATA_OE(oe)
    );

    typedef struct {
        logic we; logic [7:0] addr, din; logic [3:0] raise; logic ack, done;
        logic e_int; logic [2:0] e_id; logic [3:0] e_irq_ack; logic e_oe; logic [7:0] e_dout;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t v(input logic w, input logic [7:0] a, d, input logic [3:0] r,
                               input logic k, n, ei, input logic [2:0] eid,
                               input logic [3:0] ea, input logic eo, input logic [7:0] ed);
        vec_t x;
        x.we = w; x.addr = a; x.din = d; x.raise = r; x.ack = k; x.done = n;
        x.e_int = ei; x.e_id = eid; x.e_irq_ack = ea; x.e_oe = eo; x.e_dout = ed;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // each row: inputs for one cycle, outputs expected before that cycle's edge
        vecs.push_back(v(0,8'hE0,0,0,0,0, 0,0,0,1,8'h05));
        vecs.push_back(v(0,8'hE2,0,0,0,0, 0,0,0,1,8'h00));
        vecs.push_back(v(1,8'hE0,8'h03,0,0,0, 0,0,0,0,8'h00));
        vecs.push_back(v(0,8'hE0,0,4'h2,0,0, 0,0,0,1,8'h03));
        vecs.push_back(v(0,8'hE1,0,0,0,0, 0,0,0,1,8'h02));
        vecs.push_back(v(0,8'h00,0,0,0,0, 1,1,0,0,8'h00));
        vecs.push_back(v(0,8'hE2,0,0,1,0, 1,1,0,1,8'h41));
        vecs.push_back(v(0,8'hE1,0,0,0,0, 0,1,4'h2,1,8'h00));
        vecs.push_back(v(0,8'hE2,0,0,1,0, 0,1,0,1,8'h81));
        vecs.push_back(v(0,8'hE2,0,0,0,1, 0,1,0,1,8'h81));
        vecs.push_back(v(0,8'hE2,0,0,0,0, 0,1,0,1,8'h01));
        vecs.push_back(v(0,8'hE1,0,4'h3,0,0, 0,1,0,1,8'h00));
        vecs.push_back(v(0,8'hE1,0,0,0,0, 0,1,0,1,8'h03));
        vecs.push_back(v(0,8'h00,0,0,0,0, 1,0,0,0,8'h00));
        vecs.push_back(v(0,8'h00,0,0,1,0, 1,0,0,0,8'h00));
        vecs.push_back(v(0,8'hE1,0,0,0,0, 0,0,4'h1,1,8'h02));
        vecs.push_back(v(0,8'h00,0,0,0,1, 0,0,0,0,8'h00));
        vecs.push_back(v(0,8'hE2,0,0,0,0, 0,0,0,1,8'h00));
        vecs.push_back(v(0,8'hE2,0,0,0,0, 1,1,0,1,8'h41));
        vecs.push_back(v(0,8'h00,0,0,1,0, 1,1,0,0,8'h00));
        vecs.push_back(v(0,8'h00,0,0,0,1, 0,1,4'h2,0,8'h00));
        vecs.push_back(v(1,8'hE0,8'h00,0,0,0, 0,1,0,0,8'h00));
        vecs.push_back(v(0,8'hE0,0,4'h4,0,0, 0,1,0,1,8'h00));
        vecs.push_back(v(0,8'hE1,0,0,0,0, 0,1,0,1,8'h04));
        vecs.push_back(v(0,8'hE2,0,0,0,0, 0,1,0,1,8'h01));
        vecs.push_back(v(1,8'hE0,8'h04,0,0,0, 0,1,0,0,8'h00));
        vecs.push_back(v(0,8'hE0,0,0,0,0, 0,1,0,1,8'h04));
        vecs.push_back(v(0,8'h00,0,0,0,0, 1,2,0,0,8'h00));
        vecs.push_back(v(0,8'h00,0,0,1,0, 1,2,0,0,8'h00));
        vecs.push_back(v(0,8'h00,0,0,0,1, 0,2,4'h4,0,8'h00));
        vecs.push_back(v(1,8'hE0,8'h01,0,0,0, 0,2,0,0,8'h00));
        vecs.push_back(v(0,8'h00,0,4'h1,0,0, 0,2,0,0,8'h00));
        vecs.push_back(v(0,8'h00,0,0,0,0, 0,2,0,0,8'h00));
        vecs.push_back(v(1,8'hE0,8'h00,0,0,0, 1,0,0,0,8'h00));
        vecs.push_back(v(0,8'hE2,0,0,0,0, 1,0,0,1,8'h40));
        vecs.push_back(v(0,8'hE2,0,0,1,0, 0,0,0,1,8'h00));
        vecs.push_back(v(0,8'hE1,0,0,0,1, 0,0,0,1,8'h01));
        vecs.push_back(v(1,8'hE1,8'h01,0,0,0, 0,0,0,0,8'h00));
        vecs.push_back(v(0,8'hE1,0,0,0,0, 0,0,0,1,8'h00));
        vecs.push_back(v(0,8'hE3,0,0,0,0, 0,0,0,0,8'h00));
        vecs.push_back(v(0,8'hDF,0,0,0,0, 0,0,0,0,8'h00));

        tick;
        tick;
        rst = 1'b0;
        foreach (vecs[i]) begin
            we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
            raise = vecs[i].raise; ack = vecs[i].ack; done = vecs[i].done;
            #1;
            chk($sformatf("v%0d_cpu_int", i), 8'(cpu_int), 8'(vecs[i].e_int));
            chk($sformatf("v%0d_id", i), 8'(id), 8'(vecs[i].e_id));
            chk($sformatf("v%0d_irq_ack", i), 8'(irq_ack), 8'(vecs[i].e_irq_ack));
            chk($sformatf("v%0d_oe", i), 8'(oe), 8'(vecs[i].e_oe));
            chk($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
            tick;
        end
        we = 0; ack = 0; done = 0; raise = 0;

        // edge-set and W1C on the same bit in the same cycle
        we = 1; addr = 8'hE1; din = 8'h08; raise = 4'h8;
        tick;
        we = 0;
        #1;
        chk("set_beats_clear", dout, 8'h08);
        we = 1;
        tick;
        we = 0;
        #1;
        chk("w1c_with_level_high", dout, 8'h00);

        // level held for 50 cycles yields one request
        raise = 0; we = 1; addr = 8'hE0; din = 8'h08;
        tick;
        we = 0; addr = 8'h00; raise = 4'h8; reqs = 0;
        for (int c = 0; c < 50; c++) begin
            tick;
            ack = cpu_int;
            done = |irq_ack;
            if (cpu_int) reqs++;
        end
        raise = 0; ack = 0; done = 0;
        tick;
        chk("level_hold_requests", 8'(reqs), 8'd1);
        addr = 8'hE2;
        #1;
        chk("level_hold_idle", dout, 8'h03);

        // asynchronous reset while a request is outstanding
        we = 1; addr = 8'hE0; din = 8'h01;
        tick;
        we = 0; addr = 8'h00; raise = 4'h5;
        tick;
        raise = 0;
        tick;
        chk("pre_reset_int", 8'(cpu_int), 8'd1);
        #2;
        rst = 1;
        #1;
        chk("reset_int", 8'(cpu_int), 8'd0);
        chk("reset_irq_ack", 8'(irq_ack), 8'd0);
        addr = 8'hE1;
        #1;
        chk("reset_pending", dout, 8'h00);
        addr = 8'hE0;
        #1;
        chk("reset_mask", dout, 8'h05);
        tick;
        rst = 0; addr = 8'h00;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk($sformatf("post_reset_quiet%0d", c), 8'(cpu_int), 8'd0);
        end
        raise = 4'h4;
        tick;
        raise = 0;
        tick;
        chk("post_reset_int", 8'(cpu_int), 8'd1);
        chk("post_reset_id", 8'(id), 8'd2);

        // reset during the ack pulse drops it at once
        ack = 1;
        tick;
        ack = 0;
        chk("ack_pulse", 8'(irq_ack), 8'h04);
        #2;
        rst = 1;
        #1;
        chk("reset_drops_ack", 8'(irq_ack), 8'h00);
        tick;
        rst = 0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
